// File: rtl/traffic_phase_ctrl.sv
// Round-robin intersection controller: serves each requesting approach with
// left-turn, green, yellow and all-red clearance, with an emergency red hold.
//
// state  | meaning
// LEFT   | active approach shows left arrow + red
// GREEN  | active approach shows green
// YELLOW | active approach shows yellow
// CLEAR  | all approaches red; next approach chosen on exit
// HOLD   | emergency all-red; interrupted phase and its count are frozen
module traffic_phase_ctrl #(
  parameter  int NUM_DIR    = 2,
  parameter  int LEFT_CYC   = 5,
  parameter  int GREEN_CYC  = 10,
  parameter  int YELLOW_CYC = 3,
  parameter  int CLEAR_CYC  = 1,
  parameter  int CNT_W      = 5,
  localparam int DIR_W      = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 emergency,
  input  logic [NUM_DIR-1:0]   dir_req,
  output logic [4*NUM_DIR-1:0] lights,
  output logic [DIR_W-1:0]     active_dir,
  output logic                 preempt
);

  if (NUM_DIR < 2 || NUM_DIR > 4) begin : g_bad_num_dir
    $error("traffic_phase_ctrl: NUM_DIR must be 2..4");
  end
  if (LEFT_CYC < 1 || LEFT_CYC > (1 << CNT_W)) begin : g_bad_left
    $error("traffic_phase_ctrl: LEFT_CYC out of range for CNT_W");
  end
  if (GREEN_CYC < 1 || GREEN_CYC > (1 << CNT_W)) begin : g_bad_green
    $error("traffic_phase_ctrl: GREEN_CYC out of range for CNT_W");
  end
  if (YELLOW_CYC < 1 || YELLOW_CYC > (1 << CNT_W)) begin : g_bad_yellow
    $error("traffic_phase_ctrl: YELLOW_CYC out of range for CNT_W");
  end
  if (CLEAR_CYC < 1 || CLEAR_CYC > (1 << CNT_W)) begin : g_bad_clear
    $error("traffic_phase_ctrl: CLEAR_CYC out of range for CNT_W");
  end

  typedef enum logic [2:0] {
    ST_LEFT,
    ST_GREEN,
    ST_YELLOW,
    ST_CLEAR,
    ST_HOLD
  } state_t;

  localparam logic [CNT_W-1:0] LEFT_LD   = CNT_W'(LEFT_CYC - 1);
  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] CLEAR_LD  = CNT_W'(CLEAR_CYC - 1);

  state_t             state_q, state_d;
  state_t             saved_q, saved_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIR_W-1:0]   dir_q, dir_d;

  logic [DIR_W:0]     rot_sh;
  logic [2*NUM_DIR-1:0] req_rot;
  logic [DIR_W-1:0]   next_dir;

  // Bit k of req_rot is the request of approach (dir_q+1+k) mod NUM_DIR, so
  // the lowest set bit is the first requester in round-robin order; the top
  // bit wraps back to the current approach.
  always_comb begin
    rot_sh   = {1'b0, dir_q} + (DIR_W+1)'(1);
    req_rot  = {dir_req, dir_req} >> rot_sh;
    next_dir = DIR_W'((int'(dir_q) + 1) % NUM_DIR);
    for (int k = NUM_DIR - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        next_dir = DIR_W'((int'(dir_q) + 1 + k) % NUM_DIR);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    if (emergency) begin
      if (state_q != ST_HOLD) begin
        saved_d = state_q;
        state_d = ST_HOLD;
      end
    end else begin
      case (state_q)
        ST_HOLD: begin
          // A yellow cut short by an emergency never relights after red.
          if (saved_q == ST_YELLOW) begin
            state_d = ST_CLEAR;
            cnt_d   = CLEAR_LD;
          end else begin
            state_d = saved_q;
          end
        end
        ST_LEFT: begin
          if (cnt_q == '0) begin
            state_d = ST_GREEN;
            cnt_d   = GREEN_LD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_GREEN: begin
          if (cnt_q == '0) begin
            state_d = ST_YELLOW;
            cnt_d   = YELLOW_LD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_YELLOW: begin
          if (cnt_q == '0) begin
            state_d = ST_CLEAR;
            cnt_d   = CLEAR_LD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_CLEAR: begin
          if (cnt_q == '0) begin
            state_d = ST_LEFT;
            cnt_d   = LEFT_LD;
            dir_d   = next_dir;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_CLEAR;
          cnt_d   = CLEAR_LD;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      saved_q <= ST_CLEAR;
      cnt_q   <= CLEAR_LD;
      dir_q   <= DIR_W'(NUM_DIR - 1);
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    lights = '0;
    for (int d = 0; d < NUM_DIR; d++) begin
      lights[4*d +: 4] = 4'b0001;
      if (DIR_W'(d) == dir_q) begin
        case (state_q)
          ST_LEFT:   lights[4*d +: 4] = 4'b1001;
          ST_GREEN:  lights[4*d +: 4] = 4'b0100;
          ST_YELLOW: lights[4*d +: 4] = 4'b0010;
          default:   lights[4*d +: 4] = 4'b0001;
        endcase
      end
    end
  end

  assign active_dir = dir_q;
  assign preempt    = (state_q == ST_HOLD);

endmodule
